// File: rtl/alu_seq_hs.sv
// alu_seq_hs
//   Handshaked, registered ALU. One operation is in flight at a time.
//   Opcodes: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 NOT,
//            110 RCR, 111 MUL (iterative shift-add) or PASSB.
//   Optional feature macro: ALU_MUL_EN
//     defined   -> opcode 111 is an unsigned multiply, one bit of B per cycle
//     undefined -> opcode 111 passes B through in one cycle, busy tied low
//
// Ports
//   clk, rst_n           rising-edge clock, asynchronous active-low reset
//   in_valid / in_ready  operand handshake (inA, inB, inc, opc)
//   out_valid / out_ready result handshake (w, zer, neg, cout)
//   busy                 high while a multiply is iterating
module alu_seq_hs #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] inA,
  input  logic [WIDTH-1:0] inB,
  input  logic             inc,
  input  logic [2:0]       opc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] w,
  output logic             zer,
  output logic             neg,
  output logic             cout,
  output logic             busy
);

`ifdef ALU_MUL_EN
  typedef enum logic [1:0] {IDLE = 2'd0, DONE = 2'd1, MULT = 2'd2} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, DONE = 2'd1} state_t;
`endif

  state_t           state;
  state_t           state_nxt;
  logic             accept;
  logic [WIDTH:0]   sum_ext;
  logic [WIDTH-1:0] alu_w;
  logic             alu_c;
  logic             res_load;
  logic [WIDTH-1:0] res_w;
  logic             res_c;

  assign accept = in_valid && in_ready;

`ifdef ALU_MUL_EN
  localparam int CW = $clog2(WIDTH);

  logic          is_mul;
  logic [WIDTH-1:0] mul_a;
  logic [WIDTH-1:0] mul_hi;
  logic [WIDTH-1:0] mul_lo;
  logic [CW-1:0]    mul_cnt;
  logic [WIDTH:0]   mul_sum;

  assign is_mul = (opc == 3'b111);

  // Partial product {mul_hi, mul_lo}: mul_lo starts as B and is shifted out
  // LSB first while the running sum shifts in from the top.
  assign mul_sum = {1'b0, mul_hi} + (mul_lo[0] ? {1'b0, mul_a} : {(WIDTH+1){1'b0}});

  // Multiplier registers: loaded on a MUL accept, stepped every MUL cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mul_a   <= '0;
      mul_hi  <= '0;
      mul_lo  <= '0;
      mul_cnt <= '0;
    end else if (accept && is_mul) begin
      mul_a   <= inA;
      mul_hi  <= '0;
      mul_lo  <= inB;
      mul_cnt <= CW'(WIDTH - 1);
    end else if (state == MULT) begin
      mul_hi <= mul_sum[WIDTH:1];
      mul_lo <= {mul_sum[0], mul_lo[WIDTH-1:1]};
      if (mul_cnt != '0) begin
        mul_cnt <= mul_cnt - 1'b1;
      end
    end
  end
`endif

  // Single-cycle operations, evaluated straight from the operand inputs so
  // the result can be registered on the accept edge.
  always_comb begin
    sum_ext = '0;
    alu_w   = '0;
    alu_c   = 1'b0;
    case (opc)
      3'b000: begin
        sum_ext = {1'b0, inA} + {1'b0, inB} + {{WIDTH{1'b0}}, inc};
        alu_w   = sum_ext[WIDTH-1:0];
        alu_c   = sum_ext[WIDTH];
      end
      3'b001: begin
        // The extra top bit becomes 1 exactly when A < B + inc (borrow).
        sum_ext = {1'b0, inA} - {1'b0, inB} - {{WIDTH{1'b0}}, inc};
        alu_w   = sum_ext[WIDTH-1:0];
        alu_c   = sum_ext[WIDTH];
      end
      3'b010: alu_w = inA & inB;
      3'b011: alu_w = inA | inB;
      3'b100: alu_w = inA ^ inB;
      3'b101: alu_w = ~inA;
      3'b110: begin
        alu_w = {inc, inA[WIDTH-1:1]};
        alu_c = inA[0];
      end
      default: begin
`ifdef ALU_MUL_EN
        alu_w = '0;
`else
        alu_w = inB;
`endif
      end
    endcase
  end

  // Selects which result (if any) is written into the output registers.
  always_comb begin
    res_w = alu_w;
    res_c = alu_c;
`ifdef ALU_MUL_EN
    res_load = accept && !is_mul;
    if (state == MULT && mul_cnt == '0) begin
      res_load = 1'b1;
      res_w    = {mul_sum[0], mul_lo[WIDTH-1:1]};
      res_c    = |mul_sum[WIDTH:1];
    end
`else
    res_load = accept;
`endif
  end

  // Output registers only change when a new result is produced, so they stay
  // frozen under backpressure.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w    <= '0;
      zer  <= 1'b0;
      neg  <= 1'b0;
      cout <= 1'b0;
    end else if (res_load) begin
      w    <= res_w;
      zer  <= (res_w == '0);
      neg  <= res_w[WIDTH-1];
      cout <= res_c;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic. DONE can hand over directly to a new operation when the
  // held result is consumed on the same edge a new bundle is accepted.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept) begin
`ifdef ALU_MUL_EN
          state_nxt = is_mul ? MULT : DONE;
`else
          state_nxt = DONE;
`endif
        end
      end
      DONE: begin
        if (out_ready) begin
          if (accept) begin
`ifdef ALU_MUL_EN
            state_nxt = is_mul ? MULT : DONE;
`else
            state_nxt = DONE;
`endif
          end else begin
            state_nxt = IDLE;
          end
        end
      end
`ifdef ALU_MUL_EN
      MULT: begin
        if (mul_cnt == '0) begin
          state_nxt = DONE;
        end
      end
`endif
      default: state_nxt = IDLE;
    endcase
  end

  // Handshake and status outputs.
  always_comb begin
    out_valid = (state == DONE);
    in_ready  = (state == IDLE) || ((state == DONE) && out_ready);
`ifdef ALU_MUL_EN
    busy = (state == MULT);
`else
    busy = 1'b0;
`endif
  end

endmodule

// File: tb/tb_alu_seq_hs.sv
// tb_alu_seq_hs
//   Scoreboard bench for alu_seq_hs (WIDTH=16). Expected results are pushed
//   when a bundle is accepted; a separate monitor pops and compares whenever
//   a result is handed over. Honours ALU_MUL_EN like the design.
module tb_alu_seq_hs;
  localparam int WIDTH = 16;

  typedef struct packed {
    logic [WIDTH-1:0] w;
    logic             zer;
    logic             neg;
    logic             cout;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] inA;
  logic [WIDTH-1:0] inB;
  logic             inc;
  logic [2:0]       opc;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] w;
  logic             zer;
  logic             neg;
  logic             cout;
  logic             busy;

  logic dir_ready;
  logic rnd_ready;
  logic rnd_bp;

  exp_t expq[$];
  int   checks = 0;
  int   errors = 0;

  logic [WIDTH+2:0] held_val;
  logic             held_prev;

  assign out_ready = rnd_bp ? rnd_ready : dir_ready;

  alu_seq_hs #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .inA       (inA),
    .inB       (inB),
    .inc       (inc),
    .opc       (opc),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .w         (w),
    .zer       (zer),
    .neg       (neg),
    .cout      (cout),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Reference model: plain arithmetic on wide integers.
  function automatic exp_t ref_model(input logic [2:0] op, input logic [WIDTH-1:0] a,
                                     input logic [WIDTH-1:0] b, input logic c);
    longint unsigned ua;
    longint unsigned ub;
    longint unsigned uc;
    longint unsigned r;
    exp_t e;
    ua = longint'(a);
    ub = longint'(b);
    uc = c ? 64'd1 : 64'd0;
    e.cout = 1'b0;
    case (op)
      3'd0: begin
        r = ua + ub + uc;
        e.w = r[WIDTH-1:0];
        e.cout = r[WIDTH];
      end
      3'd1: begin
        r = ua - ub - uc;
        e.w = r[WIDTH-1:0];
        e.cout = (ua < ub + uc);
      end
      3'd2: e.w = a & b;
      3'd3: e.w = a | b;
      3'd4: e.w = a ^ b;
      3'd5: e.w = ~a;
      3'd6: begin
        e.w = {c, a[WIDTH-1:1]};
        e.cout = a[0];
      end
      default: begin
`ifdef ALU_MUL_EN
        r = ua * ub;
        e.w = r[WIDTH-1:0];
        e.cout = ((r >> WIDTH) != 64'd0);
`else
        e.w = b;
`endif
      end
    endcase
    e.zer = (e.w == '0);
    e.neg = e.w[WIDTH-1];
    return e;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  // Drives one bundle (called at posedge+1), waits for acceptance and records
  // the expected result. Returns at posedge+1 after the accept edge.
  task automatic applyStimulus(input logic [2:0] op, input logic [WIDTH-1:0] a,
                               input logic [WIDTH-1:0] b, input logic c);
    int n;
    in_valid = 1'b1;
    opc = op;
    inA = a;
    inB = b;
    inc = c;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      checkOutput("accept_timeout", 64'(in_ready), 64'd1);
    end else begin
      expq.push_back(ref_model(op, a, b, c));
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    inA = WIDTH'($urandom);
    inB = WIDTH'($urandom);
    inc = 1'($urandom);
    opc = 3'($urandom);
  endtask

  // Counts sampling points from the accept edge until out_valid shows, and how
  // many of them had busy high. Leaves the bench at posedge+1.
  task automatic measureLatency(input string name, input int exp_lat, input int exp_busy);
    int lat;
    int bcnt;
    lat = 0;
    bcnt = 0;
    do begin
      @(negedge clk);
      lat++;
      if (busy) bcnt++;
    end while (!out_valid && lat < 100);
    checkOutput({name, "_latency"}, 64'(lat), 64'(exp_lat));
    checkOutput({name, "_busy_cycles"}, 64'(bcnt), 64'(exp_busy));
    @(posedge clk);
    #1;
  endtask

  // Random backpressure source, only used in the randomized phase.
  always @(posedge clk) begin
    #1;
    rnd_ready = ($urandom_range(0, 3) != 0);
  end

  // Monitor: compares each handed-over result and checks holding under stall.
  always @(negedge clk) begin
    if (!rst_n) begin
      held_prev = 1'b0;
    end else if (out_valid && out_ready) begin
      held_prev = 1'b0;
      if (expq.size() == 0) begin
        checkOutput("spurious_result", 64'(out_valid), 64'd0);
      end else begin
        exp_t e;
        e = expq.pop_front();
        checkOutput("result_w", 64'(w), 64'(e.w));
        checkOutput("result_flags", 64'({zer, neg, cout}), 64'({e.zer, e.neg, e.cout}));
      end
    end else if (out_valid && !out_ready) begin
      checkOutput("stall_in_ready", 64'(in_ready), 64'd0);
      if (held_prev) begin
        checkOutput("stall_hold", 64'({w, zer, neg, cout}), 64'(held_val));
      end
      held_val  = {w, zer, neg, cout};
      held_prev = 1'b1;
    end else begin
      held_prev = 1'b0;
    end
  end

  initial begin
    int n;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    inA       = '0;
    inB       = '0;
    inc       = 1'b0;
    opc       = '0;
    dir_ready = 1'b1;
    rnd_bp    = 1'b0;
    held_prev = 1'b0;
    held_val  = '0;

    #12;
    checkOutput("reset_in_ready", 64'(in_ready), 64'd1);
    checkOutput("reset_out_valid", 64'(out_valid), 64'd0);
    checkOutput("reset_busy", 64'(busy), 64'd0);
    checkOutput("reset_outputs", 64'({w, zer, neg, cout}), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    $display("[TB] directed operations");
    applyStimulus(3'b000, 16'h7FFF, 16'h0001, 1'b0);
    measureLatency("add", 1, 0);
    applyStimulus(3'b001, 16'h0005, 16'h0005, 1'b0);
    measureLatency("sub_eq", 1, 0);
    applyStimulus(3'b001, 16'h0000, 16'h0001, 1'b0);
    measureLatency("sub_borrow", 1, 0);
    applyStimulus(3'b110, 16'h0003, 16'h1234, 1'b1);
    measureLatency("rcr", 1, 0);
    applyStimulus(3'b101, 16'hFFFF, 16'h5A5A, 1'b0);
    measureLatency("not", 1, 0);
    applyStimulus(3'b000, 16'hFFFF, 16'h0000, 1'b1);
    measureLatency("add_carry", 1, 0);
`ifdef ALU_MUL_EN
    applyStimulus(3'b111, 16'h0100, 16'h0100, 1'b1);
    measureLatency("mul_ovf", WIDTH + 1, WIDTH);
    applyStimulus(3'b111, 16'h00FF, 16'h0101, 1'b0);
    measureLatency("mul", WIDTH + 1, WIDTH);
`else
    applyStimulus(3'b111, 16'h1111, 16'hBEEF, 1'b1);
    measureLatency("passb", 1, 0);
`endif

    $display("[TB] backpressure");
    dir_ready = 1'b0;
    applyStimulus(3'b000, 16'h0001, 16'h0001, 1'b0);
    repeat (5) begin
      @(negedge clk);
      checkOutput("bp_out_valid", 64'(out_valid), 64'd1);
      checkOutput("bp_w", 64'(w), 64'h0002);
    end
    @(posedge clk);
    #1;
    dir_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checkOutput("bp_retired_valid", 64'(out_valid), 64'd0);
    checkOutput("bp_retired_ready", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;

`ifdef ALU_MUL_EN
    $display("[TB] reset during multiply");
    applyStimulus(3'b111, 16'h1234, 16'h0002, 1'b0);
    repeat (4) @(negedge clk);
    @(posedge clk);
    #2;
    checkOutput("mid_mul_busy", 64'(busy), 64'd1);
    rst_n = 1'b0;
    expq.delete();
    #2;
    checkOutput("mid_mul_rst_busy", 64'(busy), 64'd0);
    #2;
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("post_rst_out_valid", 64'(out_valid), 64'd0);
    checkOutput("post_rst_busy", 64'(busy), 64'd0);
    checkOutput("post_rst_in_ready", 64'(in_ready), 64'd1);
    n = 0;
    repeat (WIDTH + 8) begin
      @(negedge clk);
      if (out_valid) n++;
    end
    checkOutput("post_rst_no_result", 64'(n), 64'd0);
    @(posedge clk);
    #1;
`endif

    $display("[TB] randomized operations with backpressure");
    rnd_bp = 1'b1;
    for (int i = 0; i < 150; i++) begin
      applyStimulus(3'($urandom_range(0, 7)), WIDTH'($urandom), WIDTH'($urandom), 1'($urandom));
    end
    rnd_bp = 1'b0;

    n = 0;
    while ((expq.size() != 0 || out_valid) && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    checkOutput("drain_queue", 64'(expq.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
